// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the register file with scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    // Wide enough to hold the value nregs itself.
    function automatic int unsigned count_width(input int unsigned nregs);
        return $clog2(nregs + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with a running count of pending producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS = NREGS_DEF,
    localparam int unsigned AW    = addr_width(NREGS),
    localparam int unsigned CW    = count_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_count,
    output logic             issue_waw
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    count_q;
    logic             set_en;
    logic             inc;
    logic             dec;
    cnt_op_e          op;

    always_comb begin
        set_en = issue_valid && (issue_rd != '0);
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end

        // A clear that is overridden by a same-register issue is not a transition.
        inc = set_en && !busy_q[issue_rd];
        dec = we && busy_q[waddr] && !(set_en && (issue_rd == waddr));

        op = CNT_HOLD;
        if (inc && !dec) begin
            op = CNT_INC;
        end else if (dec && !inc) begin
            op = CNT_DEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q <= busy_d;
            case (op)
                CNT_INC: count_q <= count_q + CW'(1);
                CNT_DEC: count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;
    assign issue_waw  = issue_valid && busy_q[issue_rd];

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with write-through bypass and a busy scoreboard.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = NRD_DEF,
    localparam int unsigned AW    = addr_width(NREGS),
    localparam int unsigned CW    = count_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_waw,
    output logic [CW-1:0]     busy_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    regfile_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .we         (we),
        .waddr      (waddr),
        .busy       (busy),
        .busy_count (busy_count),
        .issue_waw  (issue_waw)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            wr_hit;
        logic [XLEN-1:0] val;

        assign addr   = raddr[p*AW +: AW];
        assign wr_hit = we && (waddr == addr);
        // x0 reads zero even when a write to it is presented this cycle.
        assign val    = (addr == '0) ? '0 :
                        wr_hit       ? wdata :
                                       regs[addr];

        assign rdata[p*XLEN +: XLEN] = val;
        assign rbusy[p]              = busy[addr] && !wr_hit;
    end

endmodule

// File: doc/regfile_bypass_sb.md
REGFILE_BYPASS_SB -- requirements
Module: regfile_bypass_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width of each register.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of two, 8..64).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL derive localparam AW = $clog2(NREGS) as the address width and CW = $clog2(NREGS+1) as the count width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, the clock.
REQ-007 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-008 SHALL have port raddr, input, NRD*AW, the packed read addresses (port i at bits [i*AW +: AW]).
REQ-009 SHALL have port rdata, output, NRD*XLEN, the packed read data.
REQ-010 SHALL have port rbusy, output, NRD, asserted when the addressed register has a pending producer.
REQ-011 SHALL have port we, input, 1, the write-back enable.
REQ-012 SHALL have port waddr, input, AW, the write-back address.
REQ-013 SHALL have port wdata, input, XLEN, the write-back data.
REQ-014 SHALL have port issue_valid, input, 1, marking that an instruction is issuing with a destination.
REQ-015 SHALL have port issue_rd, input, AW, the destination of the issuing instruction.
REQ-016 SHALL have port issue_waw, output, 1, asserted when issue_valid=1 and busy[issue_rd]=1 (combinational).
REQ-017 SHALL have port busy_count, output, CW, the number of busy registers.

Function
REQ-018 SHALL hard-wire register 0 to zero; writes to it SHALL be ignored, its busy bit SHALL never be set, and reads of it SHALL return 0 with rbusy=0.
REQ-019 SHALL perform the write at the rising edge of clk when we=1 and waddr!=0, so the written data is visible at the register output from the next cycle.
REQ-020 SHALL make reads combinational; when we=1, waddr==raddr[i] and waddr!=0, rdata[i] SHALL equal wdata in the same cycle (write-through bypass).
REQ-021 SHALL maintain one busy bit per register, set at the edge when issue_valid=1 and issue_rd!=0.
REQ-022 SHALL clear the busy bit of register waddr at the edge when we=1.
REQ-023 SHALL let set win over clear when issue_rd==waddr in the same cycle (newest producer pending), so the busy bit stays 1.
REQ-024 SHALL drive rbusy[i] = busy[raddr[i]] AND NOT (we AND waddr==raddr[i]), so a same-cycle write-back resolves the hazard.
REQ-025 SHALL update busy_count in the same cycle as the busy vector: +1 per 0->1 transition, -1 per 1->0 transition, net 0 when both occur; it SHALL never wrap (range 0..NREGS-1).
REQ-026 SHALL treat a write-back to a non-busy register as a legal write that leaves busy and busy_count unchanged.
REQ-027 SHALL treat an issue to an already-busy register as leaving busy and busy_count unchanged, with issue_waw asserted that cycle.

Reset
REQ-028 SHALL, while rst=1 at a clk edge, clear every register to 0, every busy bit to 0 and busy_count to 0; we and issue_valid SHALL be ignored during that cycle.
REQ-029 SHALL have rdata reflect zeroed registers, and rbusy, issue_waw and busy_count read 0, from the first edge after rst is asserted; rdata SHALL still show the combinational bypass of an active we.

Structure
REQ-030 SHALL take the defaults for XLEN, NREGS and NRD from shared package regfile_pkg, which also holds the AW/CW derivation helper functions.
REQ-031 SHALL place the busy bits and busy_count in a sub-module regfile_scoreboard, instantiated once; the storage array and bypass logic SHALL live in the top module.

Verification
REQ-032 SHALL verify reset: assert rst for 1 cycle after writing r5=0xDEADBEEF -> reading r5 returns 0 and busy_count=0.
REQ-033 SHALL verify write and bypass: we=1, waddr=7, wdata=0x12345678, raddr0=7 in the same cycle -> rdata0=0x12345678 immediately and on the next cycle.
REQ-034 SHALL verify x0: we=1, waddr=0, wdata=0xFFFFFFFF and issue_rd=0 -> rdata=0, rbusy=0, busy_count unchanged.
REQ-035 SHALL verify the scoreboard: issue r3 then r4 -> busy_count=2; write-back r3 -> busy_count=1, and rbusy for r3 is 0 in the write-back cycle.
REQ-036 SHALL verify simultaneous events: with r9 busy, issue_rd=9 and we/waddr=9 in the same cycle -> busy[9] stays 1, busy_count unchanged, issue_waw=1.
REQ-037 SHALL verify parameter sweep: NRD=4, NREGS=16, XLEN=64 -> all four ports read independent registers correctly after random writes.
